// File: rtl/systolic_array_wrap.sv
`default_nettype none
// ============================================================================
// Module   : systolic_array_wrap
// Brief    : N x N output-stationary systolic array computing C = A x B.
//            Includes input skew, per-PE accumulate/capture and the
//            row-by-row result drain onto c.
// Revision : 1.0 - initial release
// ============================================================================
module systolic_array_wrap #(
  parameter int SYS_ARRAY_SIZE = 4,
  parameter int DATA_W         = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   ctrl_i,
  input  logic                                   last_i,
  input  logic [SYS_ARRAY_SIZE-1:0][DATA_W-1:0]  a,
  input  logic [SYS_ARRAY_SIZE-1:0][DATA_W-1:0]  b,
  output logic [SYS_ARRAY_SIZE-1:0][DATA_W-1:0]  c
);

  // Operand/tag values arriving at each PE, and each PE's result register.
  logic [DATA_W-1:0] w_ain [SYS_ARRAY_SIZE][SYS_ARRAY_SIZE];
  logic [DATA_W-1:0] w_bin [SYS_ARRAY_SIZE][SYS_ARRAY_SIZE];
  logic              w_lin [SYS_ARRAY_SIZE][SYS_ARRAY_SIZE];
  logic [DATA_W-1:0] w_res [SYS_ARRAY_SIZE][SYS_ARRAY_SIZE];

  // Input skew: lane i of a (with its last tag) and lane i of b are delayed
  // by i stages so that slice k meets PE(i,j) exactly i+j edges later.
  genvar gi, gj;
  generate
    for (gi = 0; gi < SYS_ARRAY_SIZE; gi++) begin : g_skew
      if (gi == 0) begin : g_direct
        assign w_ain[0][0] = a[0];
        assign w_lin[0][0] = last_i;
        assign w_bin[0][0] = b[0];
      end else begin : g_dly
        logic [DATA_W-1:0] r_a_dly [gi];
        logic              r_l_dly [gi];
        logic [DATA_W-1:0] r_b_dly [gi];

        // Shift the lane through gi delay stages.
        always_ff @(posedge clk_i or negedge rst_i) begin
          if (!rst_i) begin
            for (int k = 0; k < gi; k++) begin
              r_a_dly[k] <= '0;
              r_l_dly[k] <= 1'b0;
              r_b_dly[k] <= '0;
            end
          end else begin
            r_a_dly[0] <= a[gi];
            r_l_dly[0] <= last_i;
            r_b_dly[0] <= b[gi];
            for (int k = 1; k < gi; k++) begin
              r_a_dly[k] <= r_a_dly[k-1];
              r_l_dly[k] <= r_l_dly[k-1];
              r_b_dly[k] <= r_b_dly[k-1];
            end
          end
        end

        assign w_ain[gi][0] = r_a_dly[gi-1];
        assign w_lin[gi][0] = r_l_dly[gi-1];
        assign w_bin[0][gi] = r_b_dly[gi-1];
      end
    end

    for (gi = 0; gi < SYS_ARRAY_SIZE; gi++) begin : g_row
      for (gj = 0; gj < SYS_ARRAY_SIZE; gj++) begin : g_col
        logic [DATA_W-1:0] r_acc;
        logic [DATA_W-1:0] r_res;
        logic [DATA_W-1:0] w_sum;
        logic [DATA_W-1:0] w_shift_in;

        // Product and sum are both truncated to DATA_W (modulo wrap).
        assign w_sum        = r_acc + w_ain[gi][gj] * w_bin[gi][gj];
        assign w_res[gi][gj] = r_res;

        // Row 0 pulls in zeros while draining; other rows take the row above.
        if (gi == 0) begin : g_top
          assign w_shift_in = '0;
        end else begin : g_below
          assign w_shift_in = w_res[gi-1][gj];
        end

        // Accumulate; on the last term capture the sum and restart at zero.
        // A capture on the same edge as a drain shift takes priority.
        always_ff @(posedge clk_i or negedge rst_i) begin
          if (!rst_i) begin
            r_acc <= '0;
            r_res <= '0;
          end else if (w_lin[gi][gj]) begin
            r_res <= w_sum;
            r_acc <= '0;
          end else begin
            r_acc <= w_sum;
            if (ctrl_i) begin
              r_res <= w_shift_in;
            end
          end
        end

        if (gj < SYS_ARRAY_SIZE - 1) begin : g_fwd_a
          logic [DATA_W-1:0] r_a;
          logic              r_l;

          // Pass a and its last tag to the right-hand neighbour.
          always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
              r_a <= '0;
              r_l <= 1'b0;
            end else begin
              r_a <= w_ain[gi][gj];
              r_l <= w_lin[gi][gj];
            end
          end

          assign w_ain[gi][gj+1] = r_a;
          assign w_lin[gi][gj+1] = r_l;
        end

        if (gi < SYS_ARRAY_SIZE - 1) begin : g_fwd_b
          logic [DATA_W-1:0] r_b;

          // Pass b to the neighbour below.
          always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) begin
              r_b <= '0;
            end else begin
              r_b <= w_bin[gi][gj];
            end
          end

          assign w_bin[gi+1][gj] = r_b;
        end
      end
    end

    for (gj = 0; gj < SYS_ARRAY_SIZE; gj++) begin : g_out
      assign c[gj] = w_res[SYS_ARRAY_SIZE-1][gj];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_wrap.sv
`default_nettype none
// ============================================================================
// Module   : tb_systolic_array_wrap
// Brief    : Directed self-checking bench for systolic_array_wrap (4x4, 16b).
// Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_array_wrap;

  localparam int N = 4;
  localparam int W = 16;

  logic                clk_i;
  logic                rst_i;
  logic                ctrl_i;
  logic                last_i;
  logic [N-1:0][W-1:0] a;
  logic [N-1:0][W-1:0] b;
  logic [N-1:0][W-1:0] c;

  int n_vec;
  int n_err;

  systolic_array_wrap #(
    .SYS_ARRAY_SIZE (N),
    .DATA_W         (W)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .ctrl_i (ctrl_i),
    .last_i (last_i),
    .a      (a),
    .b      (b),
    .c      (c)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [N*W-1:0] pk(input int x0, input int x1, input int x2, input int x3);
    return {x3[W-1:0], x2[W-1:0], x1[W-1:0], x0[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [N*W-1:0] got, input logic [N*W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Present one slice; returns 1ns after the edge that samples it.
  task automatic drive(input logic [N*W-1:0] av, input logic [N*W-1:0] bv, input logic lst);
    a      = av;
    b      = bv;
    last_i = lst;
    @(posedge clk_i);
    #1;
  endtask

  // Zero the inputs and let the last capture ripple through all PEs.
  task automatic settle();
    a      = '0;
    b      = '0;
    last_i = 1'b0;
    repeat (2*N-2) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse();
    ctrl_i = 1'b1;
    @(posedge clk_i);
    #1;
    ctrl_i = 1'b0;
  endtask

  // Check rows 3..0 via the drain, then the all-zero state.
  task automatic check_rows(input string tag,
                            input logic [N*W-1:0] r0, input logic [N*W-1:0] r1,
                            input logic [N*W-1:0] r2, input logic [N*W-1:0] r3);
    check({tag, "_row3"}, c, r3);
    pulse();
    check({tag, "_row2"}, c, r2);
    pulse();
    check({tag, "_row1"}, c, r1);
    pulse();
    check({tag, "_row0"}, c, r0);
    pulse();
    check({tag, "_empty"}, c, '0);
  endtask

  task automatic basic_job();
    drive(pk(4,1,2,3), pk(1,5,3,8), 1'b0);
    drive(pk(7,8,5,6), pk(2,6,4,5), 1'b0);
    drive(pk(2,3,4,1), pk(3,7,1,6), 1'b0);
    drive(pk(6,7,8,5), pk(4,8,2,7), 1'b1);
  endtask

  task automatic job2();
    drive(pk(1,2,3,4), pk(1,0,2,1), 1'b0);
    drive(pk(5,6,7,8), pk(0,1,1,3), 1'b1);
  endtask

  initial begin
    n_vec  = 0;
    n_err  = 0;
    rst_i  = 1'b0;
    ctrl_i = 1'b0;
    last_i = 1'b0;
    a      = '0;
    b      = '0;

    // Reset held with random activity on the inputs.
    repeat (3) begin
      @(negedge clk_i);
      a      = {$urandom, $urandom};
      b      = {$urandom, $urandom};
      last_i = 1'($urandom_range(0, 1));
      ctrl_i = 1'($urandom_range(0, 1));
    end
    @(negedge clk_i);
    check("reset_hold", c, '0);
    a      = '0;
    b      = '0;
    last_i = 1'b0;
    ctrl_i = 1'b0;
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check("reset_idle", c, '0);

    // Basic 4x4 job, then drain.
    basic_job();
    settle();
    check_rows("basic",
               pk(48,124,54,121), pk(54,130,52,115),
               pk(56,132,46,121), pk(38,98,44,95));

    // Back-to-back: second job starts the cycle after the first one's last.
    basic_job();
    job2();
    settle();
    check_rows("b2b",
               pk(1,5,7,16), pk(2,6,10,20),
               pk(3,7,13,24), pk(4,8,16,28));

    // Wrap: (0xFFFF*0xFFFF)*2 mod 2^16 = 2. Leave lower rows undrained.
    drive(pk(16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF), pk(16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF), 1'b0);
    drive(pk(16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF), pk(16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF), 1'b1);
    settle();
    check("wrap_row3", c, pk(2,2,2,2));
    pulse();
    check("wrap_row2", c, pk(2,2,2,2));

    // Mid-job reset: two slices in flight, asynchronous clear, fresh job.
    drive(pk(4,1,2,3), pk(1,5,3,8), 1'b0);
    drive(pk(7,8,5,6), pk(2,6,4,5), 1'b0);
    a      = '0;
    b      = '0;
    rst_i  = 1'b0;
    #2;
    check("midrst_async", c, '0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("midrst_after", c, '0);
    job2();
    settle();
    check_rows("fresh",
               pk(1,5,7,16), pk(2,6,10,20),
               pk(3,7,13,24), pk(4,8,16,28));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
